// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter for the data-cache core port, one transaction in flight.
// Ports: m0_*/m1_* master req/gnt/rvalid, s_* downstream, timeout_o sticky watchdog flag.
module mem_arbiter #(
  parameter int unsigned TIMEOUT  = 64,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_req_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_be_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  output logic        m0_err_o,
  input  logic        m1_req_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_be_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        m1_err_o,
  output logic        s_req_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_wdata_o,
  output logic        s_we_o,
  output logic [3:0]  s_be_o,
  input  logic        s_gnt_i,
  input  logic        s_rvalid_i,
  input  logic [31:0] s_rdata_i,
  input  logic        s_err_i,
  output logic        timeout_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        tmo_q, tmo_d;

  logic        win1;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;

  // M1 wins when alone, or on a tie when M0 was granted last.
  assign win1 = m1_req_i & (~m0_req_i | ~last_q);

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    be_d      = be_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    m0_gnt_o  = 1'b0;
    m1_gnt_o  = 1'b0;
    rsp_valid = 1'b0;
    rsp_data  = 32'h0;
    rsp_err   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // reset_n gates gnt so it reads 0 while reset is held
        if (reset_n && (m0_req_i || m1_req_i)) begin
          m0_gnt_o = ~win1;
          m1_gnt_o = win1;
          owner_d  = win1;
          last_d   = win1;
          addr_d   = win1 ? m1_addr_i  : m0_addr_i;
          wdata_d  = win1 ? m1_wdata_i : m0_wdata_i;
          we_d     = win1 ? m1_we_i    : m0_we_i;
          be_d     = win1 ? m1_be_i    : m0_be_i;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (s_gnt_i) begin
          cnt_d   = 8'd0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 8'd1;
        // a real response beats a coincident timeout
        if (s_rvalid_i) begin
          rsp_valid = 1'b1;
          rsp_data  = s_rdata_i;
          rsp_err   = s_err_i;
          state_d   = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          rsp_valid = 1'b1;
          rsp_data  = ERR_DATA;
          rsp_err   = 1'b1;
          tmo_d     = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      we_q    <= 1'b0;
      be_q    <= 4'h0;
      cnt_q   <= 8'd0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      be_q    <= be_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  assign m0_rvalid_o = rsp_valid & ~owner_q;
  assign m1_rvalid_o = rsp_valid & owner_q;
  assign m0_rdata_o  = owner_q ? 32'h0 : rsp_data;
  assign m1_rdata_o  = owner_q ? rsp_data : 32'h0;
  assign m0_err_o    = rsp_err & ~owner_q;
  assign m1_err_o    = rsp_err & owner_q;

  assign s_req_o   = (state_q == ISSUE);
  assign s_addr_o  = addr_q;
  assign s_wdata_o = wdata_q;
  assign s_we_o    = we_q;
  assign s_be_o    = be_q;
  assign timeout_o = tmo_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter with TIMEOUT=4.
// Driver pushes expected completions; a negedge monitor pops and compares.
module tb_mem_arbiter;

  localparam int unsigned TMO = 4;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        m0_req_i, m1_req_i;
  logic [31:0] m0_addr_i, m1_addr_i, m0_wdata_i, m1_wdata_i;
  logic        m0_we_i, m1_we_i;
  logic [3:0]  m0_be_i, m1_be_i;
  logic        m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        m0_err_o, m1_err_o;
  logic        s_req_o, s_we_o;
  logic [31:0] s_addr_o, s_wdata_o;
  logic [3:0]  s_be_o;
  logic        s_gnt_i, s_rvalid_i, s_err_i;
  logic [31:0] s_rdata_i;
  logic        timeout_o;

  mem_arbiter #(.TIMEOUT(TMO), .ERR_DATA(ERRD)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
    .m0_we_i(m0_we_i), .m0_be_i(m0_be_i), .m0_gnt_o(m0_gnt_o),
    .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o),
    .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
    .m1_we_i(m1_we_i), .m1_be_i(m1_be_i), .m1_gnt_o(m1_gnt_o),
    .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
    .s_req_o(s_req_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
    .s_we_o(s_we_o), .s_be_o(s_be_o), .s_gnt_i(s_gnt_i),
    .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i), .s_err_i(s_err_i),
    .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        owner;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int failures = 0;

  // reference state: pending master requests and arbitration history
  logic        pending [2];
  logic [31:0] p_addr [2];
  logic [31:0] p_wdata [2];
  logic        p_we [2];
  logic [3:0]  p_be [2];
  logic        last_grant;
  logic        model_tmo;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && (m0_rvalid_o || m1_rvalid_o)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rvalid", 32'(m1_rvalid_o), 32'(m0_rvalid_o));
        checks++;
        failures++;
        $display("FAIL unexpected_rvalid: got m0=%0b m1=%0b want none",
                 m0_rvalid_o, m1_rvalid_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("mon_m0_rvalid", 32'(m0_rvalid_o), 32'(!e.owner));
        chk("mon_m1_rvalid", 32'(m1_rvalid_o), 32'(e.owner));
        chk("mon_rdata", e.owner ? m1_rdata_o : m0_rdata_o, e.data);
        chk("mon_err", 32'(e.owner ? m1_err_o : m0_err_o), 32'(e.err));
        chk("mon_other_rdata", e.owner ? m0_rdata_o : m1_rdata_o, 32'h0);
        chk("mon_other_err", 32'(e.owner ? m0_err_o : m1_err_o), 32'h0);
      end
    end
  end

  task automatic drive_reqs();
    m0_req_i   = pending[0];
    m0_addr_i  = p_addr[0];
    m0_wdata_i = p_wdata[0];
    m0_we_i    = p_we[0];
    m0_be_i    = p_be[0];
    m1_req_i   = pending[1];
    m1_addr_i  = p_addr[1];
    m1_wdata_i = p_wdata[1];
    m1_we_i    = p_we[1];
    m1_be_i    = p_be[1];
  endtask

  task automatic set_m(input int m, input logic [31:0] a, input logic [31:0] w,
                       input logic we, input logic [3:0] be);
    p_addr[m]  = a;
    p_wdata[m] = w;
    p_we[m]    = we;
    p_be[m]    = be;
    pending[m] = 1'b1;
  endtask

  task automatic rand_m(input int m);
    if (!pending[m])
      set_m(m, $urandom & 32'hFFFF_FFFC, $urandom, 1'($urandom),
            4'($urandom));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One arbitration round starting at an IDLE cycle. rdel is the WAIT
  // index of the downstream response (>= TMO means it never comes).
  // rst_at >= 0 pulses reset in that WAIT cycle instead of completing.
  task automatic txn(input int gdel, input int rdel, input logic [31:0] rdat,
                     input logic rerr, input int rst_at);
    int w;
    logic [31:0] ea, ewd;
    logic ewe;
    logic [3:0] ebe;
    exp_t e;
    bit fin;
    drive_reqs();
    s_gnt_i    = 1'b0;
    s_rvalid_i = 1'($urandom);
    s_rdata_i  = $urandom;
    s_err_i    = 1'($urandom);
    w = (pending[0] && pending[1]) ? (last_grant ? 0 : 1)
                                   : (pending[0] ? 0 : 1);
    @(negedge clk);
    chk("idle_gnt0", 32'(m0_gnt_o), 32'(w == 0));
    chk("idle_gnt1", 32'(m1_gnt_o), 32'(w == 1));
    chk("idle_timeout", 32'(timeout_o), 32'(model_tmo));
    chk("idle_no_rvalid", 32'(m0_rvalid_o | m1_rvalid_o), 32'h0);
    ea  = p_addr[w];
    ewd = p_wdata[w];
    ewe = p_we[w];
    ebe = p_be[w];
    if (rst_at < 0) begin
      e.owner = 1'(w);
      e.data  = (rdel <= int'(TMO) - 1) ? rdat : ERRD;
      e.err   = (rdel <= int'(TMO) - 1) ? rerr : 1'b1;
      exp_q.push_back(e);
    end
    last_grant = 1'(w);
    pending[w] = 1'b0;
    tick();
    drive_reqs();
    for (int i = 0; i <= gdel; i++) begin
      s_gnt_i    = (i == gdel);
      s_rvalid_i = 1'($urandom);
      s_rdata_i  = $urandom;
      @(negedge clk);
      chk("issue_req", 32'(s_req_o), 32'h1);
      chk("issue_addr", s_addr_o, ea);
      chk("issue_wdata", s_wdata_o, ewd);
      chk("issue_we_be", {27'h0, s_we_o, s_be_o}, {27'h0, ewe, ebe});
      chk("issue_gnt", 32'(m0_gnt_o | m1_gnt_o), 32'h0);
      chk("issue_rvalid", 32'(m0_rvalid_o | m1_rvalid_o), 32'h0);
      tick();
    end
    s_gnt_i = 1'b0;
    for (int i = 0; i < int'(TMO); i++) begin
      if (i == rst_at) begin
        s_rvalid_i = 1'b0;
        m0_req_i   = 1'b1;
        m1_req_i   = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_gnt", 32'(m0_gnt_o | m1_gnt_o), 32'h0);
        chk("rst_rvalid", 32'(m0_rvalid_o | m1_rvalid_o), 32'h0);
        chk("rst_err", 32'(m0_err_o | m1_err_o), 32'h0);
        chk("rst_rdata", m0_rdata_o | m1_rdata_o, 32'h0);
        chk("rst_sreq", 32'(s_req_o), 32'h0);
        chk("rst_addr", s_addr_o, 32'h0);
        pending[0] = 1'b0;
        pending[1] = 1'b0;
        last_grant = 1'b1;
        model_tmo  = 1'b0;
        tick();
        reset_n = 1'b1;
        drive_reqs();
        s_rvalid_i = 1'b1;
        s_rdata_i  = $urandom;
        @(negedge clk);
        chk("post_rst_rvalid", 32'(m0_rvalid_o | m1_rvalid_o), 32'h0);
        chk("post_rst_timeout", 32'(timeout_o), 32'h0);
        tick();
        s_rvalid_i = 1'b0;
        return;
      end
      fin = (i == rdel) || (i == int'(TMO) - 1);
      s_rvalid_i = (i == rdel);
      s_rdata_i  = (i == rdel) ? rdat : $urandom;
      s_err_i    = (i == rdel) ? rerr : 1'($urandom);
      @(negedge clk);
      chk("wait_sreq", 32'(s_req_o), 32'h0);
      chk("wait_gnt", 32'(m0_gnt_o | m1_gnt_o), 32'h0);
      chk("wait_owner_rvalid", 32'(w ? m1_rvalid_o : m0_rvalid_o), 32'(fin));
      chk("wait_other_rvalid", 32'(w ? m0_rvalid_o : m1_rvalid_o), 32'h0);
      tick();
      if (fin) begin
        if (rdel > int'(TMO) - 1) model_tmo = 1'b1;
        break;
      end
    end
    s_rvalid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((pending[0] || pending[1]) && n < 4) begin
      txn(0, 0, $urandom, 1'b0, -1);
      n++;
    end
  endtask

  initial begin
    pending[0] = 1'b0;
    pending[1] = 1'b0;
    for (int m = 0; m < 2; m++) set_m(m, 32'h0, 32'h0, 1'b0, 4'h0);
    pending[0] = 1'b0;
    pending[1] = 1'b0;
    last_grant = 1'b1;
    model_tmo  = 1'b0;
    reset_n    = 1'b0;
    drive_reqs();
    m0_req_i   = 1'b1;
    m1_req_i   = 1'b1;
    s_gnt_i    = 1'b0;
    s_rvalid_i = 1'b0;
    s_rdata_i  = 32'h0;
    s_err_i    = 1'b0;
    @(negedge clk);
    chk("reset_gnt", 32'(m0_gnt_o | m1_gnt_o), 32'h0);
    chk("reset_sreq", 32'(s_req_o), 32'h0);
    chk("reset_timeout", 32'(timeout_o), 32'h0);
    chk("reset_fields", s_addr_o | s_wdata_o, 32'h0);
    tick();
    reset_n = 1'b1;
    drive_reqs();
    tick();

    set_m(0, 32'h0000_0104, 32'h0, 1'b0, 4'hF);
    txn(0, 0, 32'h1234_5678, 1'b0, -1);

    for (int k = 0; k < 4; k++) begin
      rand_m(0);
      rand_m(1);
      txn(0, 0, $urandom, 1'($urandom), -1);
    end
    drain();

    set_m(1, 32'h0000_0200, 32'hA5A5_A5A5, 1'b1, 4'b0011);
    txn(5, 1, $urandom, 1'b0, -1);

    set_m(0, 32'h0000_0300, 32'h0, 1'b0, 4'hF);
    txn(0, int'(TMO) - 1, 32'hCAFE_0001, 1'b1, -1);

    set_m(1, 32'h0000_0400, 32'h0, 1'b0, 4'hF);
    txn(1, 10, 32'h0, 1'b0, -1);
    s_rvalid_i = 1'b1;
    s_rdata_i  = 32'h5555_5555;
    @(negedge clk);
    chk("late_rvalid_dropped", 32'(m0_rvalid_o | m1_rvalid_o), 32'h0);
    chk("timeout_sticky", 32'(timeout_o), 32'h1);
    tick();
    s_rvalid_i = 1'b0;

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(1, 0) == 1) rand_m(0);
      if ($urandom_range(1, 0) == 1) rand_m(1);
      if (!pending[0] && !pending[1]) rand_m(int'($urandom_range(1, 0)));
      txn(int'($urandom_range(3, 0)), int'($urandom_range(5, 0)),
          $urandom, 1'($urandom), -1);
    end
    drain();

    rand_m(0);
    rand_m(1);
    txn(0, 5, 32'h0, 1'b0, 1);
    rand_m(0);
    rand_m(1);
    txn(0, 0, 32'h7777_0000, 1'b0, -1);
    drain();

    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master arbiter for the single core-side port of the data cache. It shares that port between the instruction-fetch master (M0) and the load/store master (M1) of the PULPino core. It uses the same req/gnt/rvalid handshake on all three ports and allows one outstanding transaction at a time. Contested requests are resolved round-robin, and a response watchdog converts a lost response into an error completion.

## Interface
Parameters:
- TIMEOUT, 64: maximum cycles spent in WAIT before a forced error completion. Valid range is 2..255; the counter is 8 bits.
- ERR_DATA, 32'hDEAD_BEEF: rdata returned on a timeout completion.

Ports:
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- m0_req_i / m1_req_i  in  1  master request
- m0_addr_i / m1_addr_i  in  32  byte address
- m0_wdata_i / m1_wdata_i  in  32  write data
- m0_we_i / m1_we_i  in  1  1 = write
- m0_be_i / m1_be_i  in  4  byte enables
- m0_gnt_o / m1_gnt_o  out  1  request accepted (combinational, IDLE only)
- m0_rvalid_o / m1_rvalid_o  out  1  completion strobe, one cycle
- m0_rdata_o / m1_rdata_o  out  32  read data, valid with rvalid
- m0_err_o / m1_err_o  out  1  error flag, valid with rvalid
- s_req_o, s_addr_o[31:0], s_wdata_o[31:0], s_we_o, s_be_o[3:0]  out  downstream request, driven from latched registers
- s_gnt_i, s_rvalid_i, s_rdata_i[31:0], s_err_i  in  downstream response
- timeout_o  out  1  sticky: set by any timeout, cleared only by reset

## Operation
State machine: IDLE, ISSUE, WAIT. Internal registers:
- owner (1 bit)
- last_grant (1 bit; reset value 1, so M0 wins the first tie)
- latched addr/wdata/we/be
- 8-bit wait counter

Transitions:
- IDLE, no request: remain in IDLE.
- IDLE, exactly one mN_req_i high: assert mN_gnt_o in the same cycle. Latch that master's addr/wdata/we/be. owner <= N, last_grant <= N, go to ISSUE.
- IDLE, both requests high: grant the master that is not last_grant; the other master's gnt stays 0. The loser keeps req asserted and is served on the next IDLE visit.
- ISSUE: s_req_o = 1 with latched fields. When s_gnt_i = 1, clear the counter and go to WAIT. If s_gnt_i stays 0, hold s_req_o and all fields stable indefinitely; there is no timeout in ISSUE.
- WAIT: s_req_o = 0. The counter increments every cycle.
  - s_rvalid_i = 1: combinationally drive owner's rvalid = 1, rdata = s_rdata_i, err = s_err_i. Go to IDLE.
  - No s_rvalid_i and counter == TIMEOUT-1: owner's rvalid = 1, rdata = ERR_DATA, err = 1. Set timeout_o, go to IDLE.
  - s_rvalid_i and the timeout in the same cycle: the real response wins, with err = s_err_i and timeout_o unchanged.

Routing and filtering:
- Non-owner rvalid/err outputs are always 0. Non-owner rdata is 0.
- s_rvalid_i is ignored in IDLE and ISSUE. A late response after a timeout is dropped.
- All gnt outputs are 0 outside IDLE, so requests arriving during ISSUE/WAIT are simply held by the masters.
- Writes and reads follow the same path; we/be/wdata pass through unmodified from the latch.

## Timing
- Reset (reset_n low, asynchronous):
  - state = IDLE, owner = 0, last_grant = 1, counter = 0.
  - Latched fields = 0, timeout_o = 0.
  - All gnt/rvalid/err/s_req outputs = 0; all rdata = 0.
- Reset mid-transaction: return to IDLE immediately. No rvalid is issued to the interrupted owner, and the downstream response, if any, is dropped.
- Minimum latency with s_gnt_i tied 1 and a one-cycle downstream:
  - Cycle 0: req and gnt.
  - Cycle 1: s_req and s_gnt.
  - Cycle 2: s_rvalid and mN_rvalid.
  - Cycle 3: IDLE, so the next grant is possible in cycle 3.
- Throughput: one transaction per 3 cycles, best case.
- Timeout: with s_gnt in cycle 1, the error rvalid occurs in cycle 1+TIMEOUT.
- gnt depends combinationally on req and state. The rvalid/rdata/err outputs depend combinationally on the s_* response inputs; there is no registered response path.

## Test plan
- Single M0 read, addr 0x0000_0104: m0_gnt in cycle 0, s_addr_o = 0x104 in cycle 1, downstream returns 0x1234_5678 in cycle 2 → m0_rvalid = 1, m0_rdata = 0x1234_5678, m0_err = 0; m1 outputs stay 0 throughout.
- Both requesting continuously from reset: grants go M0, M1, M0, M1 on successive IDLE visits; each rvalid goes only to its owner; the loser's gnt = 0 in the contested cycle.
- M1 write, addr 0x200, wdata 0xA5A5_A5A5, be 4'b0011, with s_gnt_i held 0 for 5 cycles: s_req_o and all fields stay stable for 6 cycles; WAIT is entered after s_gnt_i; m1_rvalid follows the response.
- Timeout with TIMEOUT = 4, s_rvalid never asserted: owner sees rvalid = 1, rdata = 0xDEAD_BEEF, err = 1 exactly 4 cycles after s_gnt; timeout_o = 1 and stays set. A late s_rvalid in IDLE produces no rvalid.
- Coincident s_rvalid_i and timeout cycle: rdata = s_rdata_i, err = s_err_i, timeout_o stays 0.
- reset_n pulsed low during WAIT: all outputs go 0 asynchronously; the subsequent s_rvalid is ignored; the first tie after reset grants M0.
